player_sprite_fetch: RTL and testbench

PLAYER_SPRITE_FETCH -- requirements
Module: player_sprite_fetch

---
 rtl/player_sprite_fetch_pkg.sv | 23 ++
 rtl/player_anim_fsm.sv | 59 +++++
 rtl/player_sprite_fetch.sv | 108 ++++++++++
 tb/tb_player_sprite_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_fetch_pkg.sv
// -----------------------------------------------------------------------------
// player_sprite_fetch_pkg
// Shared definitions for the player sprite fetch block: the walk-animation state
// encoding, default sprite geometry and the sprite ROM address width.
// The animation state values double as the ROM frame number (bits [11:10]).
// -----------------------------------------------------------------------------
package player_sprite_fetch_pkg;

    localparam int SPR_W_DEFAULT    = 32;
    localparam int SPR_H_DEFAULT    = 32;
    localparam int ANIM_DIV_DEFAULT = 8;

    localparam int         ROM_ADDR_W      = 12;
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef enum logic [1:0] {
        ANIM_STAND  = 2'd0,
        ANIM_WALK_A = 2'd1,
        ANIM_WALK_B = 2'd2,
        ANIM_AIR    = 2'd3
    } anim_state_e;

endpackage

// File: rtl/player_anim_fsm.sv
// -----------------------------------------------------------------------------
// player_anim_fsm
// Walk-animation state machine. Advances only on frame_start so the selected
// sprite frame is constant for a whole video frame.
// Ports:
//   Clk, Reset   - pixel clock, synchronous active-high reset
//   frame_start  - one-cycle pulse at start of vertical blank
//   moving       - player has nonzero horizontal velocity
//   airborne     - player is jumping or falling (overrides moving)
//   frame        - 2-bit sprite frame number (equals the state encoding)
// -----------------------------------------------------------------------------
module player_anim_fsm
    import player_sprite_fetch_pkg::*;
#(
    parameter int ANIM_DIV = ANIM_DIV_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       moving,
    input  logic       airborne,
    output logic [1:0] frame
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    anim_state_e      state;
    logic [CNT_W-1:0] anim_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ANIM_STAND;
            anim_cnt <= '0;
        end else if (frame_start) begin
            if (airborne) begin
                state    <= ANIM_AIR;
                anim_cnt <= '0;
            end else if (!moving) begin
                state    <= ANIM_STAND;
                anim_cnt <= '0;
            end else if (state == ANIM_STAND || state == ANIM_AIR) begin
                state    <= ANIM_WALK_A;
                anim_cnt <= '0;
            end else if (anim_cnt == CNT_LAST) begin
                // Last frame of this pose: flip between the two walk poses.
                anim_cnt <= '0;
                state    <= (state == ANIM_WALK_A) ? ANIM_WALK_B : ANIM_WALK_A;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    assign frame = state;

endmodule

// File: rtl/player_sprite_fetch.sv
// -----------------------------------------------------------------------------
// player_sprite_fetch
// Two-stage pixel pipeline that turns the current scan position into a sprite
// ROM address and then into a palette index / sprite_on flag.
// Ports:
//   Clk, Reset            - pixel clock, synchronous active-high reset
//   frame_start           - latches position/facing and steps the animation
//   DrawX, DrawY          - current scan column / row
//   player_x, player_y    - sprite top-left, sampled only at frame_start
//   facing_right          - 0 mirrors the sprite horizontally
//   moving, airborne      - animation controls
//   rom_addr              - {frame, row, col}, 0 when outside the sprite
//   rom_data              - palette index returned for rom_addr, one cycle later
//   palette_index         - index to the palette lookup, 0 outside the sprite
//   sprite_on             - inside sprite and not the transparent index
// Latency from DrawX/DrawY to palette_index/sprite_on is 2 cycles.
// -----------------------------------------------------------------------------
module player_sprite_fetch
    import player_sprite_fetch_pkg::*;
#(
    parameter int SPR_W    = SPR_W_DEFAULT,
    parameter int SPR_H    = SPR_H_DEFAULT,
    parameter int ANIM_DIV = ANIM_DIV_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [9:0]            player_x,
    input  logic [9:0]            player_y,
    input  logic                  facing_right,
    input  logic                  moving,
    input  logic                  airborne,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [3:0]            rom_data,
    output logic [3:0]            palette_index,
    output logic                  sprite_on
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);
    localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S = 11'(SPR_H);

    logic [9:0] lat_x;
    logic [9:0] lat_y;
    logic       lat_facing;
    logic       hit_d1;
    logic [1:0] frame;

    player_anim_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .moving      (moving),
        .airborne    (airborne),
        .frame       (frame)
    );

    // Offsets are computed one bit wider and signed so a scan position left of
    // or above the sprite is negative instead of wrapping into a false hit.
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               hit;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    assign dx  = $signed({1'b0, DrawX}) - $signed({1'b0, lat_x});
    assign dy  = $signed({1'b0, DrawY}) - $signed({1'b0, lat_y});
    assign hit = (dx >= 11'sd0) && (dx < SPR_W_S) &&
                 (dy >= 11'sd0) && (dy < SPR_H_S);

    // With a power-of-two width, SPR_W-1-c is simply the bitwise inverse of c.
    assign col = lat_facing ? dx[COL_W-1:0] : ~dx[COL_W-1:0];
    assign row = dy[ROW_W-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_x         <= '0;
            lat_y         <= '0;
            lat_facing    <= 1'b1;
            rom_addr      <= '0;
            hit_d1        <= 1'b0;
            palette_index <= '0;
            sprite_on     <= 1'b0;
        end else begin
            // Position and facing only move during vertical blank, so the
            // sprite never tears within a frame.
            if (frame_start) begin
                lat_x      <= player_x;
                lat_y      <= player_y;
                lat_facing <= facing_right;
            end

            // Stage 0: address generation.
            rom_addr <= hit ? ROM_ADDR_W'({frame, row, col}) : '0;
            hit_d1   <= hit;

            // Stage 1: ROM data returns; index 0 is the transparency key.
            palette_index <= hit_d1 ? rom_data : TRANSPARENT_IDX;
            sprite_on     <= hit_d1 && (rom_data != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_player_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_player_sprite_fetch
// Directed self-checking bench: a table of single-pixel vectors plus
// hand-written sequences for pipeline streaming, animation, screen edges
// and reset behaviour.
// -----------------------------------------------------------------------------
module tb_player_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY;
    logic [9:0]  player_x, player_y;
    logic        facing_right, moving, airborne;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  palette_index;
    logic        sprite_on;

    // ROM model: either a fixed value or the low nibble of the address.
    logic        rom_follow;
    logic [3:0]  rom_fixed;
    assign rom_data = rom_follow ? rom_addr[3:0] : rom_fixed;

    int n_checks = 0;
    int n_errors = 0;

    player_sprite_fetch dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .player_x      (player_x),
        .player_y      (player_y),
        .facing_right  (facing_right),
        .moving        (moving),
        .airborne      (airborne),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .palette_index (palette_index),
        .sprite_on     (sprite_on)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        face;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  rd;
        logic [11:0] exp_addr;
        logic [3:0]  exp_pal;
        logic        exp_on;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-start pulse carrying new position / animation inputs.
    task automatic do_frame(input logic [9:0] x, input logic [9:0] y, input logic face,
                            input logic mov, input logic air);
        frame_start  = 1'b1;
        player_x     = x;
        player_y     = y;
        facing_right = face;
        moving       = mov;
        airborne     = air;
        @(negedge Clk);
        frame_start  = 1'b0;
    endtask

    // Hold one pixel for two cycles; check address after one, outputs after two.
    task automatic apply_vec(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] rd, input logic [11:0] ea,
                             input logic [3:0] ep, input logic eo);
        DrawX     = x;
        DrawY     = y;
        rom_fixed = rd;
        @(negedge Clk);
        check({name, " rom_addr"}, rom_addr, ea);
        @(negedge Clk);
        check({name, " palette_index"}, 12'(palette_index), 12'(ep));
        check({name, " sprite_on"}, 12'(sprite_on), 12'(eo));
    endtask

    initial begin
        // face, x, y, rom_data -> rom_addr, palette_index, sprite_on
        vecs[0] = '{1'b1, 10'd100, 10'd200, 4'h5, 12'h000, 4'h5, 1'b1};
        vecs[1] = '{1'b1, 10'd99,  10'd200, 4'h5, 12'h000, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 10'd132, 10'd200, 4'h5, 12'h000, 4'h0, 1'b0};
        vecs[3] = '{1'b1, 10'd131, 10'd231, 4'h7, 12'h3FF, 4'h7, 1'b1};
        vecs[4] = '{1'b1, 10'd110, 10'd205, 4'h0, 12'h0AA, 4'h0, 1'b0};
        vecs[5] = '{1'b1, 10'd115, 10'd199, 4'h9, 12'h000, 4'h0, 1'b0};
        vecs[6] = '{1'b1, 10'd115, 10'd232, 4'h9, 12'h000, 4'h0, 1'b0};
        vecs[7] = '{1'b0, 10'd100, 10'd201, 4'hC, 12'h03F, 4'hC, 1'b1};
        vecs[8] = '{1'b0, 10'd131, 10'd200, 4'hF, 12'h000, 4'hF, 1'b1};
        vecs[9] = '{1'b0, 10'd110, 10'd205, 4'h3, 12'h0B5, 4'h3, 1'b1};

        Reset = 1'b1; frame_start = 1'b0;
        DrawX = '0; DrawY = '0; player_x = '0; player_y = '0;
        facing_right = 1'b1; moving = 1'b0; airborne = 1'b0;
        rom_follow = 1'b0; rom_fixed = 4'h6;

        // Reset state.
        repeat (3) @(negedge Clk);
        check("reset rom_addr", rom_addr, 12'h000);
        check("reset palette_index", 12'(palette_index), 12'h000);
        check("reset sprite_on", 12'(sprite_on), 12'h000);
        Reset = 1'b0;
        // Latched position is 0 and facing 1 straight out of reset.
        apply_vec("post-reset origin", 10'd0, 10'd0, 4'h6, 12'h000, 4'h6, 1'b1);

        // Table-driven single pixels against a sprite latched at (100,200).
        for (int i = 0; i < 10; i++) begin
            do_frame(10'd100, 10'd200, vecs[i].face, 1'b0, 1'b0);
            apply_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].rd,
                      vecs[i].exp_addr, vecs[i].exp_pal, vecs[i].exp_on);
        end

        // Streaming: a new pixel each cycle exposes the exact 2-cycle latency.
        do_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
        rom_follow = 1'b1;
        DrawY      = 10'd203;
        for (int c = 0; c < 8; c++) begin
            DrawX = 10'(99 + c);
            @(negedge Clk);
            if (c >= 1) begin
                int k;
                k = c - 1;  // input whose result is visible now
                check($sformatf("stream pal k=%0d", k), 12'(palette_index),
                      (k == 0) ? 12'h000 : 12'(k - 1));
                check($sformatf("stream on k=%0d", k), 12'(sprite_on),
                      (k >= 2) ? 12'h001 : 12'h000);
            end
        end
        rom_follow = 1'b0;

        // Animation sequence while moving.
        for (int i = 1; i <= 17; i++) begin
            do_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b0);
            if (i == 1 || i == 8 || i == 17)
                apply_vec($sformatf("walk fs%0d", i), 10'd100, 10'd200, 4'h1, 12'h400, 4'h1, 1'b1);
            else if (i == 9 || i == 16)
                apply_vec($sformatf("walk fs%0d", i), 10'd100, 10'd200, 4'h1, 12'h800, 4'h1, 1'b1);
        end
        do_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b1);
        apply_vec("airborne", 10'd100, 10'd200, 4'h1, 12'hC00, 4'h1, 1'b1);
        do_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b0);
        apply_vec("land moving", 10'd100, 10'd200, 4'h1, 12'h400, 4'h1, 1'b1);
        do_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
        apply_vec("stand", 10'd100, 10'd200, 4'h1, 12'h000, 4'h1, 1'b1);

        // Right and bottom screen edges, no wrap, mid-frame position change.
        do_frame(10'd620, 10'd100, 1'b1, 1'b0, 1'b0);
        apply_vec("edge 619", 10'd619, 10'd100, 4'h1, 12'h000, 4'h0, 1'b0);
        apply_vec("edge 620", 10'd620, 10'd100, 4'h1, 12'h000, 4'h1, 1'b1);
        apply_vec("edge 639", 10'd639, 10'd100, 4'h2, 12'h013, 4'h2, 1'b1);
        player_x = 10'd0;
        apply_vec("mid-frame x change", 10'd620, 10'd100, 4'h1, 12'h000, 4'h1, 1'b1);
        do_frame(10'd1000, 10'd470, 1'b1, 1'b0, 1'b0);
        apply_vec("no wrap hit", 10'd5, 10'd470, 4'h1, 12'h000, 4'h0, 1'b0);
        apply_vec("bottom row", 10'd1000, 10'd479, 4'h4, 12'h120, 4'h4, 1'b1);

        // Reset mid-line while visible, colliding with frame_start.
        do_frame(10'd100, 10'd200, 1'b0, 1'b1, 1'b0);
        apply_vec("pre-reset", 10'd100, 10'd200, 4'h5, 12'h41F, 4'h5, 1'b1);
        Reset = 1'b1; frame_start = 1'b1;
        player_x = 10'd300; player_y = 10'd300; facing_right = 1'b0;
        DrawX = 10'd1; DrawY = 10'd0; rom_fixed = 4'h5;
        @(negedge Clk);
        check("in-reset sprite_on", 12'(sprite_on), 12'h000);
        check("in-reset palette_index", 12'(palette_index), 12'h000);
        check("in-reset rom_addr", rom_addr, 12'h000);
        Reset = 1'b0; frame_start = 1'b0; moving = 1'b0;
        @(negedge Clk);
        check("post-release rom_addr", rom_addr, 12'h001);
        @(negedge Clk);
        check("post-release palette_index", 12'(palette_index), 12'h005);
        check("post-release sprite_on", 12'(sprite_on), 12'h001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
